// File: rtl/power_seq_pkg.sv
// Shared types and default timing constants for the power sequencer.
// Fault supervision is compiled in with POWER_SEQ_FAULT_EN.
package power_seq_pkg;

  typedef enum logic [2:0] {
    ST_OFF,
    ST_UP_WAIT,
    ST_ON,
    ST_DOWN,
    ST_FAULT
  } state_t;

  localparam int DEF_STEP_DLY   = 49999;
  localparam int DEF_PG_TIMEOUT = 499999;

endpackage

// File: rtl/power_seq_timer.sv
// Saturating step counter for the power sequencer.
// Flags the inter-rail delay and the power-good timeout.
module power_seq_timer
  import power_seq_pkg::*;
#(
  parameter int STEP_DLY   = DEF_STEP_DLY,
  parameter int PG_TIMEOUT = DEF_PG_TIMEOUT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_step_reached,
  output logic o_timeout
);

  localparam int CW = $clog2(PG_TIMEOUT + 1);

  logic [CW-1:0] r_cnt;

  // Saturates at PG_TIMEOUT so a stalled rail can never wrap back below STEP_DLY.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != CW'(PG_TIMEOUT))) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_step_reached = (r_cnt >= CW'(STEP_DLY));
  assign o_timeout      = (r_cnt == CW'(PG_TIMEOUT));

endmodule

// File: rtl/power_seq_ctrl.sv
// Multi-rail power sequencer: ramps rails up in order, down in reverse.
// Define POWER_SEQ_FAULT_EN to add power-good timeout/loss supervision.
module power_seq_ctrl
  import power_seq_pkg::*;
#(
  parameter int N_RAILS    = 3,
  parameter int STEP_DLY   = DEF_STEP_DLY,
  parameter int PG_TIMEOUT = DEF_PG_TIMEOUT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               on_req,
  input  logic               off_req,
  input  logic [N_RAILS-1:0] pg_in,
  input  logic               fault_clr,
  output logic [N_RAILS-1:0] rail_en,
  output logic               pwr_on,
  output logic               busy,
  output logic               fault
);

  localparam int             IW       = $clog2(N_RAILS);
  localparam logic [IW-1:0]  LAST_IDX = IW'(N_RAILS - 1);

  state_t             r_state;
  logic [IW-1:0]      r_idx;
  logic [N_RAILS-1:0] r_rail_en;
  logic               r_pwr_on;
  logic               r_busy;
  logic               r_fault;

  logic w_step_reached;
  logic w_timeout;
  logic w_pg_cur;
  logic w_up_step;
  logic w_dn_step;
  logic w_abort;
  logic w_fault_evt;
  logic w_tmr_clr;

  assign w_pg_cur  = pg_in[r_idx];
  assign w_up_step = (r_state == ST_UP_WAIT) && w_step_reached && w_pg_cur;
  assign w_dn_step = (r_state == ST_DOWN) && w_step_reached;
  assign w_abort   = (r_state == ST_UP_WAIT) && off_req;

`ifdef POWER_SEQ_FAULT_EN
  assign w_fault_evt = ((r_state == ST_UP_WAIT) && w_timeout && !w_pg_cur) ||
                       ((r_state == ST_ON) && (|(r_rail_en & ~pg_in)));
`else
  logic w_unused;
  assign w_unused    = &{1'b0, w_timeout};
  assign w_fault_evt = 1'b0;
`endif

  // The counter only runs while sequencing; every step restarts it from zero.
  assign w_tmr_clr = !((r_state == ST_UP_WAIT) || (r_state == ST_DOWN)) ||
                     w_up_step || w_dn_step || w_abort;

  power_seq_timer #(
    .STEP_DLY  (STEP_DLY),
    .PG_TIMEOUT(PG_TIMEOUT)
  ) u_timer (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_clr         (w_tmr_clr),
    .i_en          (1'b1),
    .o_step_reached(w_step_reached),
    .o_timeout     (w_timeout)
  );

  // rail_en stays thermometer-coded: steps shift a 1 in at the bottom or drop the top bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_OFF;
      r_idx     <= '0;
      r_rail_en <= '0;
      r_pwr_on  <= 1'b0;
      r_busy    <= 1'b0;
      r_fault   <= 1'b0;
    end else begin
      case (r_state)
        ST_OFF: begin
          if (on_req && !off_req) begin
            r_rail_en <= {{(N_RAILS-1){1'b0}}, 1'b1};
            r_idx     <= '0;
            r_busy    <= 1'b1;
            r_state   <= ST_UP_WAIT;
          end
        end
        ST_UP_WAIT: begin
          if (off_req) begin
            r_rail_en <= r_rail_en >> 1;
            r_state   <= ST_DOWN;
          end else if (w_fault_evt) begin
            r_rail_en <= '0;
            r_busy    <= 1'b0;
            r_fault   <= 1'b1;
            r_state   <= ST_FAULT;
          end else if (w_up_step) begin
            if (r_idx == LAST_IDX) begin
              r_busy   <= 1'b0;
              r_pwr_on <= 1'b1;
              r_state  <= ST_ON;
            end else begin
              r_idx     <= r_idx + IW'(1);
              r_rail_en <= {r_rail_en[N_RAILS-2:0], 1'b1};
            end
          end
        end
        ST_ON: begin
          if (off_req) begin
            r_rail_en <= r_rail_en >> 1;
            r_idx     <= LAST_IDX;
            r_pwr_on  <= 1'b0;
            r_busy    <= 1'b1;
            r_state   <= ST_DOWN;
          end else if (w_fault_evt) begin
            r_rail_en <= '0;
            r_pwr_on  <= 1'b0;
            r_fault   <= 1'b1;
            r_state   <= ST_FAULT;
          end
        end
        ST_DOWN: begin
          if (w_dn_step) begin
            if (r_idx == '0) begin
              r_busy  <= 1'b0;
              r_state <= ST_OFF;
            end else begin
              r_idx     <= r_idx - IW'(1);
              r_rail_en <= r_rail_en >> 1;
            end
          end
        end
        ST_FAULT: begin
          if (fault_clr) begin
            r_fault <= 1'b0;
            r_state <= ST_OFF;
          end
        end
        default: begin
          r_rail_en <= '0;
          r_idx     <= '0;
          r_pwr_on  <= 1'b0;
          r_busy    <= 1'b0;
          r_fault   <= 1'b0;
          r_state   <= ST_OFF;
        end
      endcase
    end
  end

  assign rail_en = r_rail_en;
  assign pwr_on  = r_pwr_on;
  assign busy    = r_busy;
  assign fault   = r_fault;

endmodule
